led_scheduler: RTL and testbench
================================

Name: led_scheduler

Overview:
Command-driven LED controller between the UART receiver and the three external LEDs. It decodes single-byte ASCII commands into static, blink or chase modes and times pattern steps with a programmable period. It returns a one-byte acknowledgement or status reply to the UART transmitter over a valid/ready handshake. It replaces direct byte-to-LED decoding and keeps compatibility with the '0'–'3' commands.

Parameters:
TICK_DIV, 12000, clocks per base tick (1 ms at 12 MHz); must be ≥2.
BASE_TICKS, 64, ticks per step at speed 0; BASE_TICKS*128 must be ≤65536.
RESET_SPEED, 3, speed index loaded at reset (0..7).

Ports:
clk  in  1  system clock
rstn  in  1  synchronous reset, active-high (reset when rstn==1)
rx_byte  in  8  received byte, valid only when rx_valid=1
rx_valid  in  1  one-cycle strobe per received byte
tx_ready  in  1  UART TX can accept tx_data this cycle
leds  out  3  LED drive, active high
mode  out  2  0=STATIC, 1=BLINK, 2=CHASE (3 unused)
speed  out  3  current speed index; step period = BASE_TICKS<<speed ticks
tx_data  out  8  reply byte
tx_valid  out  1  reply pending
ack_drop  out  1  one-cycle pulse: reply lost because slot busy

Behaviour:
- Reset, checked every clk edge: leds=000, mode=STATIC, speed=RESET_SPEED, pattern=000, tx_valid=0, tx_data=00, ack_drop=0, all counters 0. Reset mid-reply drops the pending byte.
- All outputs are registered. A command accepted at edge N is visible on leds/mode/speed after edge N.
- Commands on rx_valid (byte → action → reply):
  - '0' → pattern=000, mode=STATIC, leds=000 → 'K'(0x4B).
  - '1'/'2'/'3' → pattern=001/010/100, mode=STATIC, leds=pattern → 'K'.
  - 'B' → mode=BLINK, leds=pattern (111 if pattern==000), phase=on → 'K'.
  - 'C' → mode=CHASE, leds=001 → 'K'.
  - '+' → speed=max(speed-1,0) → 'K'.
  - '-' → speed=min(speed+1,7) → 'K'.
  - '?' → no change → status byte 0x30+{mode,speed} (5 bits).
  - 0x0D/0x0A → ignored, no reply.
  - Any other byte → no change → 'E'(0x45).
- Saturated '+' at 0 and '-' at 7 still reply 'K'.
- Timebase:
  - tick_cnt runs 0..TICK_DIV-1 and pulses tick at the terminal count.
  - per_cnt counts ticks 0..(BASE_TICKS<<speed)-1. At the terminal count with tick, per_cnt=0 and one step fires.
  - Any accepted command other than '?', CR, LF or an unknown byte clears tick_cnt and per_cnt. The new period starts from the following cycle.
- Step action:
  - STATIC: none.
  - BLINK: toggle between pattern (111 if 000) and 000.
  - CHASE: rotate left (001→010→100→001).
  - A step and rx_valid in the same cycle: the command wins and the step is discarded.
- Reply handshake (single slot):
  - A transfer occurs on tx_valid&&tx_ready. tx_data is stable while tx_valid=1.
  - New reply with slot free, or freed this cycle by a transfer: tx_data loads and tx_valid=1 next cycle.
  - New reply while tx_valid=1 and tx_ready=0: the command still executes, the reply is dropped, and ack_drop=1 for one cycle.
  - tx_valid drops the cycle after a transfer if no new reply arrives.
- Widths: tick_cnt is clog2(TICK_DIV) bits; per_cnt is 16 bits. Status arithmetic is 8-bit with no overflow (max 0x4F).

Test Plan:
Bench parameters for all scenarios: TICK_DIV=4, BASE_TICKS=2, RESET_SPEED=3.
1. Reset, then send '2' with tx_ready=1 → leds=010 next cycle; tx_data=0x4B with tx_valid=1 for one cycle. Assert rstn mid-reply with tx_ready=0 → tx_valid=0, leds=000.
2. '3' then 'B' → leds=100, then 000 after 64 clk, then 100 after 128 clk. '0' then 'B' → blinks 111/000.
3. 'C', then '+' ×3 (speed 0) → leds steps 001→010→100→001, one step every 8 clk. A fourth '+' → speed stays 0 with reply 'K'. '-' ×9 → speed=7.
4. After 'C' at speed 3, send '?' → tx_data=0x30+{2'b10,3'b011}=0x43. 'X' → 0x45 and leds unchanged. 0x0D → no tx_valid.
5. tx_ready=0, send '1' then '2' → tx_data stays 0x4B from '1', ack_drop pulses on '2', leds=010. Raise tx_ready → one transfer, then tx_valid=0.
6. Hold tx_ready=1 with rx_valid landing in the same cycle as a step → command result shown, step discarded, counters restart. A reply arriving in the same cycle as a transfer → back-to-back tx_valid with no drop.

Source files
------------

// File: rtl/led_scheduler.sv
// Command-driven LED scheduler: decodes single-byte UART commands into static,
// blink or chase patterns, paces steps from a programmable timebase, replies over valid/ready.
module led_scheduler #(
  parameter int unsigned TICK_DIV    = 12000,
  parameter int unsigned BASE_TICKS  = 64,
  parameter int unsigned RESET_SPEED = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       tx_ready,
  output logic [2:0] leds,
  output logic [1:0] mode,
  output logic [2:0] speed,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       ack_drop
);

  localparam int unsigned   TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [7:0]    ACK_K     = 8'h4B;
  localparam logic [7:0]    ERR_E     = 8'h45;
  localparam logic [7:0]    STAT_BASE = 8'h30;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CHASE  = 2'd2
  } mode_e;

  typedef enum logic [3:0] {
    CMD_NONE   = 4'd0,
    CMD_PAT    = 4'd1,
    CMD_BLINK  = 4'd2,
    CMD_CHASE  = 4'd3,
    CMD_FASTER = 4'd4,
    CMD_SLOWER = 4'd5,
    CMD_STATUS = 4'd6,
    CMD_IGNORE = 4'd7,
    CMD_ERROR  = 4'd8
  } cmd_e;

  mode_e         mode_r;
  mode_e         mode_nx_s;
  logic [2:0]    speed_r;
  logic [2:0]    speed_nx_s;
  logic [2:0]    pattern_r;
  logic [2:0]    pattern_nx_s;
  logic [2:0]    leds_nx_s;
  logic [2:0]    blink_pat_s;
  logic          phase_r;
  logic          phase_nx_s;
  logic [TW-1:0] tick_cnt_r;
  logic [15:0]   per_cnt_r;
  logic [16:0]   period_s;
  logic [15:0]   per_last_s;
  logic          tick_s;
  logic          step_s;
  cmd_e          cmd_s;
  logic [2:0]    cmd_pat_s;
  logic          restart_s;
  logic          reply_req_s;
  logic [7:0]    reply_byte_s;
  logic          slot_free_s;

  assign mode  = mode_r;
  assign speed = speed_r;

  assign tick_s      = (tick_cnt_r == TICK_LAST);
  assign period_s    = 17'(BASE_TICKS) << speed_r;
  assign per_last_s  = 16'(period_s - 17'd1);
  assign step_s      = tick_s && (per_cnt_r == per_last_s);
  assign slot_free_s = !tx_valid || tx_ready;

  // Byte decode into a command class
  always_comb begin
    cmd_s     = CMD_NONE;
    cmd_pat_s = 3'b000;
    if (rx_valid) begin
      case (rx_byte)
        8'h30:        begin cmd_s = CMD_PAT; cmd_pat_s = 3'b000; end
        8'h31:        begin cmd_s = CMD_PAT; cmd_pat_s = 3'b001; end
        8'h32:        begin cmd_s = CMD_PAT; cmd_pat_s = 3'b010; end
        8'h33:        begin cmd_s = CMD_PAT; cmd_pat_s = 3'b100; end
        8'h42:        cmd_s = CMD_BLINK;
        8'h43:        cmd_s = CMD_CHASE;
        8'h2B:        cmd_s = CMD_FASTER;
        8'h2D:        cmd_s = CMD_SLOWER;
        8'h3F:        cmd_s = CMD_STATUS;
        8'h0D, 8'h0A: cmd_s = CMD_IGNORE;
        default:      cmd_s = CMD_ERROR;
      endcase
    end else begin
      cmd_s = CMD_NONE;
    end
  end

  // Timebase restart and reply byte selection
  always_comb begin
    restart_s    = 1'b0;
    reply_req_s  = 1'b0;
    reply_byte_s = ACK_K;
    case (cmd_s)
      CMD_PAT, CMD_BLINK, CMD_CHASE, CMD_FASTER, CMD_SLOWER: begin
        restart_s    = 1'b1;
        reply_req_s  = 1'b1;
        reply_byte_s = ACK_K;
      end
      CMD_STATUS: begin
        reply_req_s  = 1'b1;
        reply_byte_s = STAT_BASE + {3'b000, mode_r, speed_r};
      end
      CMD_ERROR: begin
        reply_req_s  = 1'b1;
        reply_byte_s = ERR_E;
      end
      default: begin
        restart_s    = 1'b0;
        reply_req_s  = 1'b0;
        reply_byte_s = ACK_K;
      end
    endcase
  end

  // Next LED/mode/speed state; a command always takes priority over a step
  always_comb begin
    blink_pat_s  = (pattern_r == 3'b000) ? 3'b111 : pattern_r;
    leds_nx_s    = leds;
    pattern_nx_s = pattern_r;
    mode_nx_s    = mode_r;
    speed_nx_s   = speed_r;
    phase_nx_s   = phase_r;
    case (cmd_s)
      CMD_PAT: begin
        pattern_nx_s = cmd_pat_s;
        mode_nx_s    = MODE_STATIC;
        leds_nx_s    = cmd_pat_s;
      end
      CMD_BLINK: begin
        mode_nx_s  = MODE_BLINK;
        leds_nx_s  = blink_pat_s;
        phase_nx_s = 1'b1;
      end
      CMD_CHASE: begin
        mode_nx_s = MODE_CHASE;
        leds_nx_s = 3'b001;
      end
      CMD_FASTER: begin
        if (speed_r != 3'd0) begin
          speed_nx_s = speed_r - 3'd1;
        end else begin
          speed_nx_s = speed_r;
        end
      end
      CMD_SLOWER: begin
        if (speed_r != 3'd7) begin
          speed_nx_s = speed_r + 3'd1;
        end else begin
          speed_nx_s = speed_r;
        end
      end
      CMD_NONE: begin
        if (step_s) begin
          case (mode_r)
            MODE_BLINK: begin
              phase_nx_s = !phase_r;
              leds_nx_s  = phase_r ? 3'b000 : blink_pat_s;
            end
            MODE_CHASE: leds_nx_s = {leds[1:0], leds[2]};
            default:    leds_nx_s = leds;
          endcase
        end else begin
          leds_nx_s = leds;
        end
      end
      default: begin
        leds_nx_s = leds;
      end
    endcase
  end

  // Tick prescaler and step period counter
  always_ff @(posedge clk) begin
    if (rstn) begin
      tick_cnt_r <= {TW{1'b0}};
      per_cnt_r  <= 16'd0;
    end else if (restart_s) begin
      tick_cnt_r <= {TW{1'b0}};
      per_cnt_r  <= 16'd0;
    end else if (tick_s) begin
      tick_cnt_r <= {TW{1'b0}};
      per_cnt_r  <= step_s ? 16'd0 : per_cnt_r + 16'd1;
    end else begin
      tick_cnt_r <= tick_cnt_r + TW'(1);
    end
  end

  // LED, mode, speed and pattern registers
  always_ff @(posedge clk) begin
    if (rstn) begin
      leds      <= 3'b000;
      mode_r    <= MODE_STATIC;
      speed_r   <= 3'(RESET_SPEED);
      pattern_r <= 3'b000;
      phase_r   <= 1'b0;
    end else begin
      leds      <= leds_nx_s;
      mode_r    <= mode_nx_s;
      speed_r   <= speed_nx_s;
      pattern_r <= pattern_nx_s;
      phase_r   <= phase_nx_s;
    end
  end

  // Single-slot reply buffer; a reply that finds the slot occupied is dropped
  always_ff @(posedge clk) begin
    if (rstn) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      ack_drop <= 1'b0;
    end else if (reply_req_s) begin
      if (slot_free_s) begin
        tx_data  <= reply_byte_s;
        tx_valid <= 1'b1;
        ack_drop <= 1'b0;
      end else begin
        ack_drop <= 1'b1;
      end
    end else begin
      ack_drop <= 1'b0;
      if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
      end else begin
        tx_valid <= tx_valid;
      end
    end
  end

endmodule

// File: tb/tb_led_scheduler.sv
// Self-checking bench for led_scheduler: directed scenarios plus random traffic,
// compared every cycle against a behavioural model of the command/timing rules.
module tb_led_scheduler;

  localparam int TD = 4;
  localparam int BT = 2;
  localparam int RS = 3;

  logic       clk;
  logic       rstn;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       tx_ready;
  logic [2:0] leds;
  logic [1:0] mode;
  logic [2:0] speed;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       ack_drop;

  int n_checks;
  int n_pass;

  // Reference state
  logic [2:0] m_leds;
  logic [1:0] m_mode;
  logic [2:0] m_speed;
  logic [2:0] m_pat;
  bit         m_on;
  int         m_elapsed;
  bit         m_txv;
  logic [7:0] m_txd;
  bit         m_ack;

  led_scheduler #(
    .TICK_DIV   (TD),
    .BASE_TICKS (BT),
    .RESET_SPEED(RS)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .tx_ready(tx_ready),
    .leds    (leds),
    .mode    (mode),
    .speed   (speed),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .ack_drop(ack_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int period_clks(input logic [2:0] spd);
    return TD * (BT * (1 << spd));
  endfunction

  // Apply one clock edge of the specification's rules to the model
  task automatic model_edge();
    bit         step;
    bit         restart;
    bit         rep_req;
    logic [7:0] rep;
    int         n;
    if (rstn) begin
      m_leds = 3'b000; m_mode = 2'd0; m_speed = 3'(RS); m_pat = 3'b000; m_on = 1'b0;
      m_elapsed = 0; m_txv = 1'b0; m_txd = 8'h00; m_ack = 1'b0;
      return;
    end
    m_elapsed = m_elapsed + 1;
    step = (m_elapsed % period_clks(m_speed)) == 0;
    restart = 1'b0;
    rep_req = 1'b0;
    rep = 8'h00;
    if (rx_valid) begin
      if (rx_byte >= 8'h30 && rx_byte <= 8'h33) begin
        n = int'(rx_byte) - 48;
        m_pat = (n == 0) ? 3'b000 : 3'(1 << (n - 1));
        m_mode = 2'd0; m_leds = m_pat;
        restart = 1'b1; rep_req = 1'b1; rep = 8'h4B;
      end else if (rx_byte == 8'h42) begin
        m_mode = 2'd1; m_on = 1'b1;
        m_leds = (m_pat == 3'b000) ? 3'b111 : m_pat;
        restart = 1'b1; rep_req = 1'b1; rep = 8'h4B;
      end else if (rx_byte == 8'h43) begin
        m_mode = 2'd2; m_leds = 3'b001;
        restart = 1'b1; rep_req = 1'b1; rep = 8'h4B;
      end else if (rx_byte == 8'h2B) begin
        if (m_speed > 0) m_speed = m_speed - 3'd1;
        restart = 1'b1; rep_req = 1'b1; rep = 8'h4B;
      end else if (rx_byte == 8'h2D) begin
        if (m_speed < 7) m_speed = m_speed + 3'd1;
        restart = 1'b1; rep_req = 1'b1; rep = 8'h4B;
      end else if (rx_byte == 8'h3F) begin
        rep_req = 1'b1; rep = 8'(48 + int'(m_mode) * 8 + int'(m_speed));
      end else if (rx_byte == 8'h0D || rx_byte == 8'h0A) begin
        rep_req = 1'b0;
      end else begin
        rep_req = 1'b1; rep = 8'h45;
      end
    end else if (step) begin
      if (m_mode == 2'd1) begin
        m_on = !m_on;
        m_leds = m_on ? ((m_pat == 3'b000) ? 3'b111 : m_pat) : 3'b000;
      end else if (m_mode == 2'd2) begin
        m_leds = (m_leds == 3'b100) ? 3'b001 : 3'(m_leds * 2);
      end
    end
    if (restart) m_elapsed = 0;
    if (rep_req) begin
      if (!m_txv || tx_ready) begin
        m_txd = rep; m_txv = 1'b1; m_ack = 1'b0;
      end else begin
        m_ack = 1'b1;
      end
    end else begin
      m_ack = 1'b0;
      if (m_txv && tx_ready) m_txv = 1'b0;
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic [7:0] b, input logic rdy);
    rstn = r; rx_valid = v; rx_byte = b; tx_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
    check_val("leds", 32'(leds), 32'(m_leds));
    check_val("mode", 32'(mode), 32'(m_mode));
    check_val("speed", 32'(speed), 32'(m_speed));
    check_val("tx_valid", 32'(tx_valid), 32'(m_txv));
    check_val("tx_data", 32'(tx_data), 32'(m_txd));
    check_val("ack_drop", 32'(ack_drop), 32'(m_ack));
  endtask

  task automatic send(input logic [7:0] b, input logic rdy);
    cyc(1'b0, 1'b1, b, rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, rdy);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  // Idle until the next edge would fire a step, then deliver a command on it
  task automatic send_on_step(input logic [7:0] b);
    int guard;
    guard = 0;
    while (((m_elapsed + 1) % period_clks(m_speed)) != 0 && guard < 2000) begin
      idle(1, 1'b1);
      guard++;
    end
    check_val("step_wait", 32'(guard < 2000), 32'd1);
    send(b, 1'b1);
  endtask

  logic [7:0] cmd_tab [12];

  initial begin
    n_checks = 0; n_pass = 0;
    rstn = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; tx_ready = 1'b0;
    cmd_tab = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h42, 8'h43, 8'h2B, 8'h2D, 8'h3F, 8'h58, 8'h0D, 8'h0A};

    // Reset state and basic '2' command
    do_reset();
    check_val("rst_leds", 32'(leds), 32'h0);
    check_val("rst_speed", 32'(speed), 32'd3);
    check_val("rst_txv", 32'(tx_valid), 32'h0);
    send(8'h32, 1'b1);
    check_val("s1_leds", 32'(leds), 32'b010);
    check_val("s1_txd", 32'(tx_data), 32'h4B);
    check_val("s1_txv", 32'(tx_valid), 32'h1);
    idle(1, 1'b1);
    check_val("s1_txv_drop", 32'(tx_valid), 32'h0);
    send(8'h31, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    check_val("s1_rst_txv", 32'(tx_valid), 32'h0);
    check_val("s1_rst_leds", 32'(leds), 32'h0);

    // Blink from pattern 100, then blink with empty pattern
    send(8'h33, 1'b1);
    send(8'h42, 1'b1);
    check_val("s2_on", 32'(leds), 32'b100);
    idle(63, 1'b1);
    check_val("s2_still_on", 32'(leds), 32'b100);
    idle(1, 1'b1);
    check_val("s2_off", 32'(leds), 32'b000);
    idle(64, 1'b1);
    check_val("s2_on_again", 32'(leds), 32'b100);
    send(8'h30, 1'b1);
    send(8'h42, 1'b1);
    check_val("s2_blink7", 32'(leds), 32'b111);
    idle(140, 1'b1);

    // Chase at speed 0, saturation on both ends
    send(8'h43, 1'b1);
    for (int i = 0; i < 3; i++) send(8'h2B, 1'b1);
    check_val("s3_speed0", 32'(speed), 32'd0);
    idle(8, 1'b1);
    check_val("s3_step1", 32'(leds), 32'b010);
    idle(16, 1'b1);
    check_val("s3_step3", 32'(leds), 32'b001);
    send(8'h2B, 1'b1);
    check_val("s3_sat_lo", 32'(speed), 32'd0);
    check_val("s3_sat_ack", 32'(tx_data), 32'h4B);
    for (int i = 0; i < 9; i++) send(8'h2D, 1'b1);
    check_val("s3_sat_hi", 32'(speed), 32'd7);

    // Status, unknown and ignored bytes
    do_reset();
    send(8'h43, 1'b1);
    send(8'h3F, 1'b1);
    check_val("s4_status", 32'(tx_data), 32'h43);
    idle(1, 1'b1);
    send(8'h58, 1'b1);
    check_val("s4_err", 32'(tx_data), 32'h45);
    check_val("s4_leds", 32'(leds), 32'b001);
    idle(1, 1'b1);
    send(8'h0D, 1'b1);
    check_val("s4_cr", 32'(tx_valid), 32'h0);

    // Reply dropped while the slot is held
    send(8'h31, 1'b0);
    send(8'h32, 1'b0);
    check_val("s5_drop", 32'(ack_drop), 32'h1);
    check_val("s5_txd", 32'(tx_data), 32'h4B);
    check_val("s5_leds", 32'(leds), 32'b010);
    idle(1, 1'b1);
    check_val("s5_done", 32'(tx_valid), 32'h0);

    // Command colliding with a step; back-to-back replies
    send(8'h43, 1'b1);
    send(8'h2B, 1'b1);
    send(8'h2B, 1'b1);
    send_on_step(8'h3F);
    send_on_step(8'h2D);
    send_on_step(8'h31);
    send(8'h43, 1'b1);
    send(8'h3F, 1'b1);
    check_val("s6_b2b_drop", 32'(ack_drop), 32'h0);
    check_val("s6_b2b_valid", 32'(tx_valid), 32'h1);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        cyc(1'b1, 1'b0, 8'h00, 1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 11) == 0) begin
          cyc(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 9) < 7));
        end else begin
          cyc(1'b0, 1'b1, cmd_tab[$urandom_range(0, 11)], 1'($urandom_range(0, 9) < 7));
        end
      end else begin
        cyc(1'b0, 1'b0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 9) < 7));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
